// File: rtl/uart_axi_pkg.sv
// rtl/uart_axi_pkg.sv - shared FSM states, AXI response code and UART Lite status bit positions
package uart_axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    S_AR,
    S_R,
    D_AR,
    D_R
  } rx_state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam int STAT_RX_VALID = 0;
  localparam int STAT_OVERRUN  = 5;
  localparam int STAT_FRAME    = 6;
  localparam int STAT_PARITY   = 7;

  // Status-register error bits packed as {frame, parity, overrun}
  function automatic logic [2:0] stat_err_bits(input logic [7:0] stat);
    return {stat[STAT_FRAME], stat[STAT_PARITY], stat[STAT_OVERRUN]};
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous byte FIFO, power-of-two depth, occupancy count
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pop on empty is ignored; a push into a full FIFO is accepted only alongside a pop
  assign do_pop   = pop && (count != '0);
  assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage array, no reset needed since reads are gated by count
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_stream.sv
// rtl/uart_rx_stream.sv - polls UART Lite status, fetches RX bytes into a local FIFO stream; sticky errors under UART_RX_ERR_EN
module uart_rx_stream
  import uart_axi_pkg::*;
#(
  parameter int                ADDR_W    = 4,
  parameter int                DEPTH     = 16,
  parameter logic [ADDR_W-1:0] RX_ADDR   = 'h0,
  parameter logic [ADDR_W-1:0] STAT_ADDR = 'h8,
  parameter int                POLL_GAP  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic [ADDR_W-1:0]      m_araddr,
  output logic                   m_arvalid,
  input  logic                   m_arready,
  input  logic [31:0]            m_rdata,
  input  logic [1:0]             m_rresp,
  input  logic                   m_rvalid,
  output logic                   m_rready,
  output logic [7:0]             rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic [$clog2(DEPTH):0] rx_count,
  output logic [2:0]             err,
  input  logic                   err_clr
);

  localparam int CW = $clog2(DEPTH) + 1;

  rx_state_e  state;
  rx_state_e  state_nx;
  logic [7:0] gap_cnt;
  logic [7:0] gap_nx;
  logic       push;
  logic       pop;
  logic       resp_ok;
  logic       slot_free;
  logic       unused_bits;

  assign pop       = rx_valid && rx_ready;
  assign resp_ok   = (m_rresp == RESP_OKAY);
  // Only one byte is ever in flight, so a free slot now (or one being freed this cycle) is guaranteed at D_R
  assign slot_free = (rx_count < CW'(DEPTH)) || pop;
  assign rx_valid  = (rx_count != '0);
  assign unused_bits = ^{m_rdata[31:8], err_clr};

  // State and poll-gap registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nx;
      gap_cnt <= gap_nx;
    end
  end

  // Next state, AXI read channel outputs and FIFO push
  always_comb begin
    state_nx  = state;
    gap_nx    = gap_cnt;
    m_arvalid = 1'b0;
    m_araddr  = STAT_ADDR;
    m_rready  = 1'b0;
    push      = 1'b0;
    unique case (state)
      IDLE: begin
        if (gap_cnt != 8'd0) gap_nx = gap_cnt - 8'd1;
        else if (en)         state_nx = S_AR;
      end
      S_AR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_nx = S_R;
      end
      S_R: begin
        m_rready = 1'b1;
        if (m_rvalid) begin
          if (m_rdata[STAT_RX_VALID] && resp_ok && slot_free) begin
            state_nx = D_AR;
          end else begin
            state_nx = IDLE;
            gap_nx   = 8'(POLL_GAP);
          end
        end
      end
      D_AR: begin
        m_arvalid = 1'b1;
        m_araddr  = RX_ADDR;
        if (m_arready) state_nx = D_R;
      end
      D_R: begin
        m_rready = 1'b1;
        if (m_rvalid) begin
          push     = resp_ok;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  uart_rx_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (m_rdata[7:0]),
    .pop       (pop),
    .pop_data  (rx_data),
    .count     (rx_count)
  );

`ifdef UART_RX_ERR_EN
  logic [2:0] err_q;
  logic [2:0] err_set;

  // Error sources: status flags on OKAY status reads, overrun slot also flags any bad response
  always_comb begin
    err_set = 3'b000;
    if ((state == S_R) && m_rvalid) err_set = resp_ok ? stat_err_bits(m_rdata[7:0]) : 3'b001;
    if ((state == D_R) && m_rvalid && !resp_ok) err_set = 3'b001;
  end

  // Sticky flags; a set in the same cycle as a clear survives
  always_ff @(posedge clk) begin
    if (rst) err_q <= 3'b000;
    else     err_q <= (err_clr ? 3'b000 : err_q) | err_set;
  end

  assign err = err_q;
`else
  assign err = 3'b000;
`endif

endmodule

// File: tb/tb_uart_rx_stream.sv
// tb/tb_uart_rx_stream.sv - randomized bench with behavioural AXI-Lite UART slave and stream reference model
module tb_uart_rx_stream;

  localparam int              ADDR_W    = 4;
  localparam int              DEPTH     = 16;
  localparam logic [3:0]      RX_ADDR   = 4'h0;
  localparam logic [3:0]      STAT_ADDR = 4'h8;
  localparam int              POLL_GAP  = 4;
`ifdef UART_RX_ERR_EN
  localparam logic [2:0]      T7_ERR    = 3'b001;
`else
  localparam logic [2:0]      T7_ERR    = 3'b000;
`endif

  logic              clk;
  logic              rst;
  logic              en;
  logic [ADDR_W-1:0] m_araddr;
  logic              m_arvalid;
  logic              m_arready;
  logic [31:0]       m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rvalid;
  logic              m_rready;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [4:0]        rx_count;
  logic [2:0]        err;
  logic              err_clr;

  uart_rx_stream #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RX_ADDR(RX_ADDR), .STAT_ADDR(STAT_ADDR), .POLL_GAP(POLL_GAP)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_count(rx_count),
    .err(err), .err_clr(err_clr)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Slave configuration and state
  logic [7:0]  src_q[$];
  logic [7:0]  stat_hi = 8'h00;
  logic        force_data = 1'b0;
  logic        rand_mode = 1'b0;
  int          ar_delay = 0;
  int          r_delay = 0;
  int          sl_st = 0;
  int          dly = 0;
  int          rdly = 0;
  logic [3:0]  sl_addr = 4'h0;

  // Behavioural AXI-Lite UART slave, driven one step after each rising edge
  initial begin
    logic [7:0] b;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        m_arready = 1'b0; m_rvalid = 1'b0; sl_st = 0;
      end else begin
        if (sl_st == 3) begin m_rvalid = 1'b0; sl_st = 0; end
        if (sl_st == 2) begin
          m_arready = 1'b0;
          rdly = rand_mode ? $urandom_range(0, 2) : r_delay;
          sl_st = 4;
        end
        if (sl_st == 4) begin
          if (rdly == 0) begin
            if (sl_addr == STAT_ADDR) begin
              m_rdata = {24'h0, stat_hi[7:1], (src_q.size() != 0) || force_data};
            end else begin
              b = (src_q.size() != 0) ? src_q.pop_front() : 8'($urandom);
              m_rdata = $urandom;
              m_rdata[7:0] = b;
            end
            m_rresp = (rand_mode && $urandom_range(0, 15) == 0) ? 2'b10 : 2'b00;
            m_rvalid = 1'b1;
            sl_st = 3;
          end else rdly--;
        end
        if (sl_st == 0 && m_arvalid) begin
          sl_addr = m_araddr;
          dly = rand_mode ? $urandom_range(0, 3) : ar_delay;
          sl_st = 1;
        end
        if (sl_st == 1) begin
          if (dly == 0) begin m_arready = 1'b1; sl_st = 2; end
          else dly--;
        end
      end
    end
  end

  // Reference model: expected stream, occupancy, sticky errors and AXI protocol rules
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         stat_cyc[$];
  int         cnt_m = 0;
  logic [2:0] err_m = 3'b000;
  int         n_pops = 0, n_drop = 0, n_ar = 0, n_rx_ar = 0;
  logic       prev_ar_pend = 1'b0, prev_r_hs = 1'b0;
  logic [3:0] prev_addr = 4'h0;

  initial forever begin
    logic ar_hs, r_hs, pop_m;
    logic [2:0] eset;
    @(negedge clk);
    if (rst) begin
      cnt_m = 0; exp_q.delete(); err_m = 3'b000; prev_ar_pend = 1'b0; prev_r_hs = 1'b0;
    end else begin
      check_eq("rx_count", rx_count, cnt_m);
      check_eq("rx_valid", rx_valid, cnt_m != 0);
      check_eq("err", err, err_m);
      if (prev_ar_pend) begin
        check_eq("arvalid_held", m_arvalid, 1);
        check_eq("araddr_held", m_araddr, prev_addr);
      end
      if (m_rvalid) check_eq("rready_held", m_rready, 1);
      if (prev_r_hs) check_eq("rready_drop", m_rready, 0);
      ar_hs = m_arvalid && m_arready;
      r_hs  = m_rvalid && m_rready;
      pop_m = rx_ready && (cnt_m != 0);
      if (pop_m) begin
        check_eq("rx_data", rx_data, exp_q[0]);
        got_q.push_back(rx_data);
        void'(exp_q.pop_front());
        cnt_m--;
        n_pops++;
      end
      if (ar_hs) begin
        n_ar++;
        if (m_araddr == RX_ADDR) n_rx_ar++;
        else stat_cyc.push_back(cyc);
      end
      eset = 3'b000;
      if (r_hs) begin
        if (sl_addr == RX_ADDR) begin
          if (m_rresp == 2'b00) begin
            check_eq("no_overflow", cnt_m < DEPTH, 1);
            exp_q.push_back(m_rdata[7:0]);
            cnt_m++;
          end else n_drop++;
        end
        if (m_rresp != 2'b00) eset[0] = 1'b1;
        else if (sl_addr == STAT_ADDR) eset = {m_rdata[6], m_rdata[7], m_rdata[5]};
      end
`ifdef UART_RX_ERR_EN
      err_m = (err_clr ? 3'b000 : err_m) | eset;
`endif
      prev_ar_pend = m_arvalid && !m_arready;
      prev_addr    = m_araddr;
      prev_r_hs    = r_hs;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    en = 1'b0;
    wait_cycles(25);
  endtask

  initial begin
    int bp, br, ba, fed, bd, found;
    rst = 1'b1; en = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
    wait_cycles(3);
    @(negedge clk);
    check_eq("rst_arvalid", m_arvalid, 0);
    check_eq("rst_rready", m_rready, 0);
    check_eq("rst_araddr", m_araddr, STAT_ADDR);
    check_eq("rst_rx_valid", rx_valid, 0);
    check_eq("rst_rx_count", rx_count, 0);
    check_eq("rst_err", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // In-order stream of three bytes
    bp = n_pops;
    src_q.push_back(8'h41); src_q.push_back(8'h42); src_q.push_back(8'h43);
    rx_ready = 1'b1; en = 1'b1;
    for (int i = 0; i < 300 && n_pops < bp + 3; i++) wait_cycles(1);
    check_eq("t1_count", n_pops - bp, 3);
    for (int i = 0; i < 3; i++) check_eq("t1_byte", got_q[bp + i], 32'h41 + i);
    go_idle();

    // FIFO fills to DEPTH and no further byte is fetched
    rx_ready = 1'b0; force_data = 1'b1; br = n_rx_ar;
    en = 1'b1;
    wait_cycles(300);
    check_eq("t2_full", rx_count, DEPTH);
    check_eq("t2_reads", n_rx_ar - br, DEPTH);
    go_idle();
    force_data = 1'b0; rx_ready = 1'b1;
    wait_cycles(40);
    check_eq("t2_drained", rx_count, 0);

    // Delayed arready
    ar_delay = 3; bp = n_pops; br = n_rx_ar;
    src_q.push_back(8'h5a);
    en = 1'b1;
    wait_cycles(60);
    go_idle();
    check_eq("t3_reads", n_rx_ar - br, 1);
    check_eq("t3_pops", n_pops - bp, 1);
    check_eq("t3_byte", got_q[$], 8'h5a);
    ar_delay = 0;

    // Poll spacing with no data available
    stat_cyc.delete(); br = n_rx_ar;
    en = 1'b1;
    wait_cycles(60);
    go_idle();
    check_eq("t4_polls", stat_cyc.size() >= 5, 1);
    for (int i = 1; i < stat_cyc.size() && i < 5; i++)
      check_eq("t4_gap", stat_cyc[i] - stat_cyc[i-1], 3 + POLL_GAP);
    check_eq("t4_no_rx", n_rx_ar - br, 0);

    // en dropped while the data read is outstanding
    r_delay = 2; bp = n_pops; found = 0;
    src_q.push_back(8'h77);
    en = 1'b1;
    for (int i = 0; i < 100 && found == 0; i++) begin
      @(negedge clk);
      if (sl_st == 4 && sl_addr == RX_ADDR) found = 1;
    end
    en = 1'b0;
    ba = n_ar;
    check_eq("t5_found", found, 1);
    wait_cycles(30);
    check_eq("t5_no_ar", n_ar - ba, 0);
    check_eq("t5_pops", n_pops - bp, 1);
    check_eq("t5_byte", got_q[$], 8'h77);
    @(negedge clk);
    check_eq("t5_arvalid", m_arvalid, 0);
    r_delay = 0;

    // Randomized traffic, delays, bad responses and consumer backpressure
    rand_mode = 1'b1; fed = 0; bp = n_pops; bd = n_drop;
    for (int i = 0; i < 3000; i++) begin
      wait_cycles(1);
      rx_ready = ($urandom_range(0, 3) != 0);
      en = ($urandom_range(0, 31) != 0);
      stat_hi = ($urandom_range(0, 63) == 0) ? (8'($urandom) & 8'he0) : 8'h00;
      if ($urandom_range(0, 3) == 0 && src_q.size() < 40) begin
        src_q.push_back(8'($urandom));
        fed++;
      end
    end
    en = 1'b1; rx_ready = 1'b1; stat_hi = 8'h00;
    for (int i = 0; i < 3000 && src_q.size() != 0; i++) wait_cycles(1);
    go_idle();
    rand_mode = 1'b0;
    check_eq("t6_src_empty", src_q.size(), 0);
    check_eq("t6_rx_count", rx_count, 0);
    check_eq("t6_delivered", n_pops - bp, fed - (n_drop - bd));

    // Sticky error flags from status 0x21, then clear
    err_clr = 1'b1; wait_cycles(1); err_clr = 1'b0;
    stat_hi = 8'h20; bp = n_pops;
    src_q.push_back(8'h33);
    en = 1'b1;
    wait_cycles(40);
    go_idle();
    @(negedge clk);
    check_eq("t7_err", err, T7_ERR);
    check_eq("t7_byte", got_q[$], 8'h33);
    check_eq("t7_pops", n_pops - bp, 1);
    stat_hi = 8'h00;
    @(posedge clk); #1;
    err_clr = 1'b1; wait_cycles(1); err_clr = 1'b0;
    @(negedge clk);
    check_eq("t7_err_clr", err, 0);

    // Reset in the middle of traffic
    rx_ready = 1'b0; force_data = 1'b1; en = 1'b1;
    wait_cycles(33);
    rst = 1'b1;
    wait_cycles(2);
    @(negedge clk);
    check_eq("t8_rx_count", rx_count, 0);
    check_eq("t8_rx_valid", rx_valid, 0);
    check_eq("t8_arvalid", m_arvalid, 0);
    check_eq("t8_rready", m_rready, 0);
    check_eq("t8_araddr", m_araddr, STAT_ADDR);
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b0; force_data = 1'b0;
    wait_cycles(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
